// File: rtl/depacketer_pkg.sv
// Framing constants and shared types for the packeter/depacketer byte-stream link.
package depacketer_pkg;

    localparam logic [7:0] PACKET_MAGIC   = 8'hFE;
    localparam logic [7:0] PACKET_ESCAPED = 8'hFE;
    localparam logic [7:0] PACKET_SAMPLE  = 8'h01;
    localparam logic [7:0] PACKET_PPS     = 8'h02;
    localparam logic [7:0] PACKET_RESP    = 8'h03;
    localparam logic [7:0] PACKET_END     = 8'h88;

    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_SAMPLE = 2'd1;
    localparam logic [1:0] SRC_PPS    = 2'd2;
    localparam logic [1:0] SRC_RESP   = 2'd3;

    localparam int DEFAULT_SAMPLE_SIZE = 513;
    localparam int DEFAULT_PPS_SIZE    = 4;
    localparam int DEFAULT_RESP_SIZE   = 1;
    localparam int CNT_W               = 10;

    typedef enum logic [1:0] {
        S_HUNT,
        S_TYPE,
        S_DATA,
        S_ESCAPE
    } state_t;

    // Type bytes 01/02/03 map directly onto the 2-bit source code.
    function automatic logic is_header(input logic [7:0] b);
        return (b == PACKET_SAMPLE) || (b == PACKET_PPS) || (b == PACKET_RESP);
    endfunction

endpackage

// File: rtl/depacketer.sv
// Framed-stream receiver: hunts magic, decodes type, strips FE escape doubling and
// demuxes payload bytes to sample/PPS/response strobes, counting framing errors.
module depacketer
    import depacketer_pkg::*;
#(
    parameter int SAMPLE_PACKET_SIZE = DEFAULT_SAMPLE_SIZE,
    parameter int PPS_PACKET_SIZE    = DEFAULT_PPS_SIZE,
    parameter int RESP_PACKET_SIZE   = DEFAULT_RESP_SIZE
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        sample_valid,
    output logic [7:0]  sample_data,
    output logic        pps_valid,
    output logic [7:0]  pps_data,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        pkt_done,
    output logic [1:0]  pkt_type,
    output logic        err,
    output logic [15:0] err_count
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, hdr_cnt;
    logic [1:0]       dest, dest_n;
    logic             emit, done, ferr;

    always_comb begin
        case (in_data[1:0])
            SRC_SAMPLE: hdr_cnt = CNT_W'(SAMPLE_PACKET_SIZE);
            SRC_PPS:    hdr_cnt = CNT_W'(PPS_PACKET_SIZE);
            default:    hdr_cnt = CNT_W'(RESP_PACKET_SIZE);
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dest_n  = dest;
        emit    = 1'b0;
        done    = 1'b0;
        ferr    = 1'b0;
        if (in_valid) begin
            case (state)
                S_HUNT: begin
                    if (in_data == PACKET_MAGIC) state_n = S_TYPE;
                end
                S_TYPE: begin
                    if (is_header(in_data)) begin
                        cnt_n   = hdr_cnt;
                        dest_n  = in_data[1:0];
                        state_n = S_DATA;
                    end else begin
                        // A bare FE here is the tail of an escaped pair seen while unsynced.
                        ferr    = (in_data != PACKET_MAGIC);
                        state_n = S_HUNT;
                    end
                end
                S_DATA: begin
                    if (in_data == PACKET_MAGIC) begin
                        state_n = S_ESCAPE;
                    end else begin
                        emit  = 1'b1;
                        cnt_n = cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            done    = 1'b1;
                            state_n = S_HUNT;
                        end
                    end
                end
                S_ESCAPE: begin
                    if (in_data == PACKET_ESCAPED) begin
                        emit    = 1'b1;
                        cnt_n   = cnt - 1'b1;
                        done    = (cnt == CNT_W'(1));
                        state_n = done ? S_HUNT : S_DATA;
                    end else if (is_header(in_data)) begin
                        // Truncated packet: the FE was really a new magic, take its header now.
                        ferr    = 1'b1;
                        cnt_n   = hdr_cnt;
                        dest_n  = in_data[1:0];
                        state_n = S_DATA;
                    end else begin
                        ferr    = 1'b1;
                        state_n = S_HUNT;
                    end
                end
                default: state_n = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state        <= S_HUNT;
            cnt          <= '0;
            dest         <= SRC_NONE;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            pps_valid    <= 1'b0;
            pps_data     <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            pkt_done     <= 1'b0;
            pkt_type     <= '0;
            err          <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            dest         <= dest_n;
            sample_valid <= emit && (dest == SRC_SAMPLE);
            pps_valid    <= emit && (dest == SRC_PPS);
            resp_valid   <= emit && (dest == SRC_RESP);
            if (emit && dest == SRC_SAMPLE) sample_data <= in_data;
            if (emit && dest == SRC_PPS)    pps_data    <= in_data;
            if (emit && dest == SRC_RESP)   resp_data   <= in_data;
            pkt_done     <= done;
            if (done) pkt_type <= dest;
            err          <= ferr;
            if (ferr && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

endmodule
